// File: rtl/regbank_write_arbiter_pkg.sv
// Shared register-bank constants used by the bank and its write arbiter.
package regbank_write_arbiter_pkg;

    // Default register data width and register index width (32 registers).
    localparam int unsigned RegDataW = 32;
    localparam int unsigned RegAddrW = 5;

    // Number of write requesters sharing the single bank write port.
    localparam int unsigned NumReq = 2;

    // Width of the issued-write counter.
    localparam int unsigned WrCountW = 16;

    // Round-robin pointer value after a transfer: the requester that did not win.
    function automatic logic next_prio(input logic winner_id);
        return ~winner_id;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational; the pointer lives in the caller.
module rr_arb2
    import regbank_write_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] valid,
    input  logic              prio,
    output logic [NumReq-1:0] grant
);

    // Lone requester always wins; a contested cycle goes to the requester prio points at.
    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates two write requesters onto one register-bank write port with
// latency 1, throughput 1 and round-robin fairness on contention.
module regbank_write_arbiter
    import regbank_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RegDataW,
    parameter int unsigned ADDR_W = RegAddrW
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_dr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,

    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_dr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,

    output logic                write,
    output logic [ADDR_W-1:0]   dr,
    output logic [DATA_W-1:0]   wrData,
    output logic                grant_id,
    output logic [WrCountW-1:0] wr_count
);

    logic [NumReq-1:0] valid;
    logic [NumReq-1:0] grant;
    logic [NumReq-1:0] xfer;
    logic              xfer_any;
    logic              win_id;

    logic                prio_q,     prio_d;
    logic                write_q,    write_d;
    logic [ADDR_W-1:0]   dr_q,       dr_d;
    logic [DATA_W-1:0]   wr_data_q,  wr_data_d;
    logic                grant_id_q, grant_id_d;
    logic [WrCountW-1:0] wr_count_q, wr_count_d;

    assign valid = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .valid (valid),
        .prio  (prio_q),
        .grant (grant)
    );

    // Ready is gated by reset so nothing is accepted (and thus lost) while reset is high.
    assign req0_ready = grant[0] & ~reset;
    assign req1_ready = grant[1] & ~reset;

    // Grant is only ever given to a valid requester, so ready alone marks the transfer.
    assign xfer     = {req1_ready, req0_ready};
    assign xfer_any = |xfer;
    assign win_id   = xfer[1];

    // Next-state: capture the winning write, move the pointer, count issued writes.
    always_comb begin
        write_d    = xfer_any;
        dr_d       = dr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        prio_d     = prio_q;
        wr_count_d = wr_count_q;
        if (xfer_any) begin
            dr_d       = win_id ? req1_dr   : req0_dr;
            wr_data_d  = win_id ? req1_data : req0_data;
            grant_id_d = win_id;
            prio_d     = next_prio(win_id);
            // Counted on acceptance so the count updates together with write going high.
            wr_count_d = wr_count_q + {{(WrCountW-1){1'b0}}, 1'b1};
        end
    end

    // Output registers, pointer and counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b0;
            write_q    <= 1'b0;
            dr_q       <= '0;
            wr_data_q  <= '0;
            grant_id_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            prio_q     <= prio_d;
            write_q    <= write_d;
            dr_q       <= dr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign write    = write_q;
    assign dr       = dr_q;
    assign wrData   = wr_data_q;
    assign grant_id = grant_id_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter: stream-based requesters, a
// transaction-level arbitration model, a register-bank stub and a monitor.
module tb_regbank_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_dr = '0, req1_dr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          write;
    logic [AW-1:0] dr;
    logic [DW-1:0] wrData;
    logic          grant_id;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    regbank_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_dr    (req0_dr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dr    (req1_dr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .write      (write),
        .dr         (dr),
        .wrData     (wrData),
        .grant_id   (grant_id),
        .wr_count   (wr_count)
    );

    typedef struct {
        logic [AW-1:0] dr;
        logic [DW-1:0] data;
        bit            id;
    } wr_t;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit            prio_m = 1'b0;
    logic [15:0]   cnt_m = '0;
    logic [AW-1:0] last_dr = '0;
    logic [DW-1:0] last_data = '0;
    bit            last_id = 1'b0;
    wr_t           exp_q[$];
    logic [AW-1:0] s0_dr[$], s1_dr[$];
    logic [DW-1:0] s0_d[$], s1_d[$];
    bit            hold0 = 1'b0, hold1 = 1'b0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] bank_dut[32];
    logic [DW-1:0] bank_exp[32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register bank stub fed straight from the arbiter outputs.
    always @(posedge clk) begin
        if (write === 1'b1) bank_dut[dr] <= wrData;
    end

    // Monitor: every cycle the output port must match the head of the scoreboard or hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_write: got write=1 dr=%0d data=%0h expected no write",
                             dr, wrData);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_dr", 64'(dr), 64'(e.dr));
                    chk("wr_data", 64'(wrData), 64'(e.data));
                    chk("wr_grant_id", 64'(grant_id), 64'(e.id));
                    last_dr   = e.dr;
                    last_data = e.data;
                    last_id   = e.id;
                end
            end else begin
                chk("missing_write", 64'(exp_q.size()), 64'd0);
                chk("hold_dr", 64'(dr), 64'(last_dr));
                chk("hold_data", 64'(wrData), 64'(last_data));
                chk("hold_grant_id", 64'(grant_id), 64'(last_id));
            end
            chk("wr_count", 64'(wr_count), 64'(cnt_m));
        end
    end

    task automatic present(input int idle_pct, output bit v0, output bit v1);
        v0 = (s0_dr.size() > 0) && (hold0 || ($urandom_range(99) >= idle_pct));
        v1 = (s1_dr.size() > 0) && (hold1 || ($urandom_range(99) >= idle_pct));
        req0_valid = v0;
        req0_dr    = v0 ? s0_dr[0] : AW'($urandom);
        req0_data  = v0 ? s0_d[0]  : $urandom;
        req1_valid = v1;
        req1_dr    = v1 ? s1_dr[0] : AW'($urandom);
        req1_data  = v1 ? s1_d[0]  : $urandom;
    endtask

    // One normal cycle: model picks the winner from the arbitration rules.
    task automatic step(input int idle_pct);
        bit  v0, v1;
        int  w;
        wr_t e;
        present(idle_pct, v0, v1);
        @(negedge clk);
        w = -1;
        if (v0 && v1)  w = prio_m ? 1 : 0;
        else if (v0)   w = 0;
        else if (v1)   w = 1;
        chk("req0_ready", 64'(req0_ready), 64'(w == 0));
        chk("req1_ready", 64'(req1_ready), 64'(w == 1));
        @(posedge clk);
        if (w == 0) begin
            e.dr = s0_dr.pop_front(); e.data = s0_d.pop_front(); e.id = 1'b0;
        end else if (w == 1) begin
            e.dr = s1_dr.pop_front(); e.data = s1_d.pop_front(); e.id = 1'b1;
        end
        if (w >= 0) begin
            exp_q.push_back(e);
            bank_exp[e.dr] = e.data;
            prio_m = (w == 0);
            cnt_m  = cnt_m + 16'd1;
        end
        hold0 = v0 && (w != 0);
        hold1 = v1 && (w != 1);
        #1;
    endtask

    // One reset cycle with pending requests still presented; nothing may be accepted.
    task automatic reset_pulse();
        bit v0, v1;
        reset = 1'b1;
        present(0, v0, v1);
        @(negedge clk);
        chk("rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clk);
        prio_m = 1'b0; cnt_m = '0;
        last_dr = '0; last_data = '0; last_id = 1'b0;
        hold0 = v0; hold1 = v1;
        #1;
        reset = 1'b0;
    endtask

    task automatic run(input int idle_pct, input int budget);
        int n = 0;
        while ((s0_dr.size() + s1_dr.size()) > 0 && n < budget) begin
            step(idle_pct);
            n++;
        end
        if ((s0_dr.size() + s1_dr.size()) > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d requests left expected 0",
                     s0_dr.size() + s1_dr.size());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0);
    endtask

    task automatic push_req(input bit id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin s1_dr.push_back(a); s1_d.push_back(d); end
        else    begin s0_dr.push_back(a); s0_d.push_back(d); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin bank_dut[k] = '0; bank_exp[k] = '0; end
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;

        // Single requester: accepted at once, visible one cycle later.
        push_req(1'b0, 5'd3, 32'd30);
        run(0, 10);
        idle(2);

        // Continuous contention alternates 0,1,0,1 after reset.
        reset_pulse();
        for (int k = 1; k <= 4; k++) begin
            push_req(1'b0, AW'(k), DW'(100 + k));
            push_req(1'b1, AW'(8 + k), DW'(200 + k));
        end
        run(0, 20);
        idle(2);

        // Same destination: loser's value is the last one written.
        reset_pulse();
        push_req(1'b0, 5'd7, 32'd70);
        push_req(1'b1, 5'd7, 32'd71);
        run(0, 10);
        idle(2);
        chk("r7_final", 64'(bank_dut[7]), 64'd71);

        // Reset during a pending req1 cycle, then both valid: req0 must win first.
        push_req(1'b1, 5'd5, 32'd55);
        reset_pulse();
        push_req(1'b0, 5'd6, 32'd66);
        run(0, 10);
        idle(2);

        // All 32 registers via alternating requesters.
        reset_pulse();
        for (int k = 0; k < 32; k++) push_req(k[0], AW'(k), DW'(10 * k));
        run(0, 100);
        idle(2);
        for (int k = 0; k < 32; k++) chk($sformatf("reg%0d", k), 64'(bank_dut[k]), 64'(10 * k));
        chk("wr_count_32", 64'(wr_count), 64'd32);

        // Randomized traffic with occasional resets (some landing on an in-flight write).
        reset_pulse();
        repeat (600) begin
            if (s0_dr.size() < 4) push_req(1'b0, AW'($urandom), $urandom);
            if (s1_dr.size() < 4) push_req(1'b1, AW'($urandom), $urandom);
            if ($urandom_range(59) == 0) reset_pulse();
            else step(30);
        end
        run(30, 200);
        idle(2);

        // Counter wrap: 65535 writes to reach FFFF, one more wraps to 0.
        reset_pulse();
        for (int k = 0; k < 65536; k++) push_req(k[0], AW'(k), DW'(k));
        run(0, 66000);
        idle(2);
        chk("wr_count_wrap", 64'(wr_count), 64'd0);

        for (int k = 0; k < 32; k++)
            chk($sformatf("bank%0d", k), 64'(bank_dut[k]), 64'(bank_exp[k]));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
